// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Arbitrates NREQ requesters that each offer a pair of signed DW-bit operands.
// The winner's pair is summed at DW+1 bits, clipped to the signed DW-bit range
// and held in a one-entry output register (EMPTY/FULL) until the consumer
// takes it. A new pair can be accepted in the same cycle the held result
// leaves, so one result per cycle is sustained. Arbitration is round-robin
// (MODE=0) or fixed lowest-index priority (MODE=1), over requesters enabled
// in MASK. A small register bus exposes MASK, MODE, STATUS and SATCNT.
//
// Optional feature macro: ADDER_ARBITER_GRANT_STATS_EN
//   Defined   : per-requester 32-bit acceptance counters at 0x10 + 4*k,
//               cleared together by any write to 0x10.
//   Undefined : no counters; 0x10 onward reads 0.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester operand-pair valid
//   req_ready_o  per-requester accept (one-hot or zero)
//   req_in1_i    packed first operands, requester k at [k*DW +: DW]
//   req_in2_i    packed second operands, same packing
//   res_valid_o  result held and valid
//   res_ready_i  downstream takes the result when high with res_valid_o
//   res_data_o   saturated sum
//   res_id_o     requester that produced res_data_o
//   res_sat_o    res_data_o was clipped
//   addr/wen/ren/wdata  register bus request
//   ack/rdata    register bus response, one cycle after the request
//
// Register map
//   0x00 MASK   [NREQ-1:0] RW   (reset all ones)
//   0x04 MODE   [0]        RW   (0 = round-robin, 1 = fixed priority)
//   0x08 STATUS RO  {PTR[10:8], FULL[4], res_id_o[2:0]}
//   0x0C SATCNT RO  count of saturated accepted sums, wraps
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*DW-1:0]   req_in1_i,
  input  logic [NREQ*DW-1:0]   req_in2_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [DW-1:0]        res_data_o,
  output logic [2:0]           res_id_o,
  output logic                 res_sat_o,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [31:0]          wdata,
  output logic                 ack,
  output logic [31:0]          rdata
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [2:0]    LAST_IDX = 3'(NREQ - 1);
  localparam logic [DW-1:0] SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

  // Result-side state
  state_e          state_q;
  logic [DW-1:0]   res_data_q;
  logic [2:0]      res_id_q;
  logic            res_sat_q;
  logic [2:0]      ptr_q;
  logic [2:0]      ptr_d;
  logic [31:0]     satcnt_q;

  // Register bus state
  logic [NREQ-1:0] mask_q;
  logic            mode_q;
  logic            ack_q;
  logic [31:0]     rdata_q;

  // Arbitration and datapath
  logic [NREQ-1:0] elig;
  logic            low_found;
  logic [2:0]      low_idx;
  logic            hi_found;
  logic [2:0]      hi_idx;
  logic [2:0]      win_idx;
  logic            can_accept;
  logic            accept;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [DW:0]     sum_w;
  logic            sum_ovf;
  logic [DW-1:0]   sum_sat;
  logic [31:0]     rd_val;

  // Upper write-data bits have no register behind them.
  logic            unused_wdata;
  assign unused_wdata = ^wdata[31:NREQ];

  // Winner search. low_* is the lowest eligible index overall; hi_* is the
  // lowest eligible index at or above the round-robin pointer. Round-robin
  // takes hi_* and wraps to low_* when nothing sits at or above the pointer.
  // NOTE: every signal gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    elig      = req_valid_i & mask_q;
    low_found = 1'b0;
    low_idx   = '0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    // Descending scan: the last hit is the lowest qualifying index.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        low_found = 1'b1;
        low_idx   = 3'(k);
        if (3'(k) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(k);
        end
      end
    end
    if (mode_q || !hi_found) win_idx = low_idx;
    else                     win_idx = hi_idx;
  end

  // A new pair may enter when the output register is free or is being
  // emptied this very cycle; under backpressure nothing is accepted.
  assign can_accept = !rst_i && ((state_q == EMPTY) || res_ready_i);
  assign accept     = can_accept && low_found;

  always_comb begin
    req_ready_o = '0;
    op_a        = '0;
    op_b        = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready_o[k] = accept && (win_idx == 3'(k));
      if (win_idx == 3'(k)) begin
        op_a = req_in1_i[k*DW +: DW];
        op_b = req_in2_i[k*DW +: DW];
      end
    end
  end

  // Sign-extend both operands by one bit so the sum cannot wrap; overflow of
  // the DW-bit range shows up as the two top bits disagreeing.
  assign sum_w   = {op_a[DW-1], op_a} + {op_b[DW-1], op_b};
  assign sum_ovf = sum_w[DW] ^ sum_w[DW-1];
  assign sum_sat = !sum_ovf   ? sum_w[DW-1:0] :
                   sum_w[DW]  ? SAT_MIN       : SAT_MAX;

  assign ptr_d = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;

  // EMPTY/FULL controller with its registered result outputs. Without an
  // acceptance the result registers hold, which freezes the outputs while
  // the consumer applies backpressure.
  // NOTE: clocked state is assigned with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_sat_q  <= 1'b0;
      ptr_q      <= '0;
      satcnt_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (res_ready_i && !accept) state_q <= EMPTY;
      endcase
      if (accept) begin
        res_data_q <= sum_sat;
        res_id_q   <= win_idx;
        res_sat_q  <= sum_ovf;
        ptr_q      <= ptr_d;
        if (sum_ovf) satcnt_q <= satcnt_q + 32'd1;
      end
    end
  end

  assign res_valid_o = (state_q == FULL);
  assign res_data_o  = res_data_q;
  assign res_id_o    = res_id_q;
  assign res_sat_o   = res_sat_q;

`ifdef ADDER_ARBITER_GRANT_STATS_EN
  logic [31:0] grant_cnt_q [NREQ];

  // NOTE: this counter array is deliberately reset element by element; it is
  // plain flops, not a RAM, so reset costs nothing special here.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NREQ; k++) begin
      if (rst_i || (wen && (addr == 16'h0010))) begin
        grant_cnt_q[k] <= '0;
      end else if (accept && (win_idx == 3'(k))) begin
        grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
      end
    end
  end
`endif

  // Read mux over the pre-write register values, so a combined read and
  // write returns what was there before the write.
  always_comb begin
    rd_val = '0;
    case (addr)
      16'h0000: rd_val[NREQ-1:0] = mask_q;
      16'h0004: rd_val[0]        = mode_q;
      16'h0008: begin
        rd_val[10:8] = ptr_q;
        rd_val[4]    = (state_q == FULL);
        rd_val[2:0]  = res_id_q;
      end
      16'h000C: rd_val = satcnt_q;
      default:  rd_val = '0;
    endcase
`ifdef ADDER_ARBITER_GRANT_STATS_EN
    for (int k = 0; k < NREQ; k++) begin
      if (addr == 16'(16 + 4 * k)) rd_val = grant_cnt_q[k];
    end
`endif
  end

  // Bus response and writable registers. A write becomes visible to the
  // arbiter on the next cycle; the held result is not touched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      mask_q  <= '1;
      mode_q  <= 1'b0;
    end else begin
      ack_q   <= wen | ren;
      rdata_q <= ren ? rd_val : 32'd0;
      if (wen) begin
        case (addr)
          16'h0000: mask_q <= wdata[NREQ-1:0];
          16'h0004: mode_q <= wdata[0];
          default:  ;
        endcase
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Directed bench for adder_arbiter (NREQ=4, DW=14). Expected results are
// computed from a saturating-add model and queued when the operands are
// driven; a monitor pops and compares them whenever a result transfer occurs.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 14;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NREQ-1:0]     req_valid_i;
  logic [NREQ-1:0]     req_ready_o;
  logic [NREQ*DW-1:0]  req_in1_i;
  logic [NREQ*DW-1:0]  req_in2_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [DW-1:0]       res_data_o;
  logic [2:0]          res_id_o;
  logic                res_sat_o;
  logic [15:0]         addr;
  logic                wen;
  logic                ren;
  logic [31:0]         wdata;
  logic                ack;
  logic [31:0]         rdata;

  adder_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_in1_i   (req_in1_i),
    .req_in2_i   (req_in2_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_id_o    (res_id_o),
    .res_sat_o   (res_sat_o),
    .addr        (addr),
    .wen         (wen),
    .ren         (ren),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]    id;
    logic [DW-1:0] data;
    logic          sat;
  } res_t;

  res_t sb[$];
  res_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic res_t model(input int id, input int a, input int b);
    res_t r;
    int   s;
    s     = a + b;
    r.id  = 3'(id);
    r.sat = 1'b0;
    if (s > SMAX) begin
      s     = SMAX;
      r.sat = 1'b1;
    end else if (s < SMIN) begin
      s     = SMIN;
      r.sat = 1'b1;
    end
    r.data = DW'(s);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input int a, input int b);
    req_valid_i[k]          = 1'b1;
    req_in1_i[k*DW +: DW]   = DW'(a);
    req_in2_i[k*DW +: DW]   = DW'(b);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    ren  = 1'b1;
    tick();
    ren  = 1'b0;
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check(tag, rdata, exp);
  endtask

  // Result monitor: every transfer must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && res_valid_o && res_ready_i) begin
      if (sb.size() == 0) begin
        check("result_without_expectation", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("res_id",   32'(res_id_o),   32'(mon_e.id));
        check("res_data", 32'(res_data_o), 32'(mon_e.data));
        check("res_sat",  32'(res_sat_o),  32'(mon_e.sat));
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '1;
    req_in1_i   = '0;
    req_in2_i   = '0;
    res_ready_i = 1'b1;
    addr        = '0;
    wen         = 1'b0;
    ren         = 1'b0;
    wdata       = '0;

    // ---- Reset state ----
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_valid", 32'(res_valid_o), 32'd0);
    check("rst_data",  32'(res_data_o),  32'd0);
    check("rst_id",    32'(res_id_o),    32'd0);
    check("rst_sat",   32'(res_sat_o),   32'd0);
    check("rst_ack",   32'(ack),         32'd0);
    check("rst_rdata", rdata,            32'd0);
    tick();
    rst_i       = 1'b0;
    req_valid_i = '0;

    bus_read(16'h0000, 32'h0000_000F, "mask_rst");
    bus_read(16'h0004, 32'h0,         "mode_rst");
    bus_read(16'h0008, 32'h0,         "status_rst");
    bus_read(16'h000C, 32'h0,         "satcnt_rst");
    tick();
    check("ack_one_cycle", 32'(ack), 32'd0);

    // ---- Round-robin over four always-valid requesters: ids 0,1,2,3,0 ----
    for (int k = 0; k < NREQ; k++) set_req(k, 100 * k + 1, 10 * k);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model(i % 4, 100 * (i % 4) + 1, 10 * (i % 4)));
      @(negedge clk_i);
      check("rr_ready", 32'(req_ready_o), 32'(4'b0001 << (i % 4)));
      tick();
    end
    req_valid_i = '0;
    tick();
    @(negedge clk_i);
    check("rr_drained", 32'(res_valid_o), 32'd0);
    tick();

    // ---- Saturation at both ends, plus exact-boundary sums ----
    set_req(2, 8000, 500);
    sb.push_back(model(2, 8000, 500));
    tick();
    req_valid_i = '0;
    tick();
    bus_read(16'h000C, 32'd1, "satcnt_pos");
    set_req(2, -8000, -500);
    sb.push_back(model(2, -8000, -500));
    tick();
    req_valid_i = '0;
    tick();
    bus_read(16'h000C, 32'd2, "satcnt_neg");
    set_req(1, SMAX, 0);
    sb.push_back(model(1, SMAX, 0));
    tick();
    req_valid_i = '0;
    set_req(3, SMIN, 0);
    sb.push_back(model(3, SMIN, 0));
    tick();
    req_valid_i = '0;
    tick();
    bus_read(16'h000C, 32'd2, "satcnt_edge");

    // ---- Backpressure: hold FULL for 5 cycles, then release ----
    res_ready_i = 1'b0;
    set_req(0, 5, 6);
    sb.push_back(model(0, 5, 6));
    @(negedge clk_i);
    check("bp_accept_when_empty", 32'(req_ready_o), 32'd1);
    tick();
    set_req(0, 100, 200);
    set_req(1, 7, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_ready", 32'(req_ready_o), 32'd0);
      check("bp_valid", 32'(res_valid_o), 32'd1);
      check("bp_data",  32'(res_data_o),  32'd11);
      check("bp_id",    32'(res_id_o),    32'd0);
      tick();
    end
    res_ready_i = 1'b1;
    sb.push_back(model(1, 7, 8));
    @(negedge clk_i);
    check("bp_release_ready", 32'(req_ready_o), 32'b0010);
    tick();
    req_valid_i = '0;
    tick();

    // ---- Fixed priority with requester 0 masked ----
    bus_write(16'h0004, 32'h1);
    bus_write(16'h0000, 32'hE);
    for (int k = 0; k < NREQ; k++) set_req(k, k + 1, k + 2);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(1, 2, 3));
      @(negedge clk_i);
      check("fp_ready", 32'(req_ready_o), 32'b0010);
      tick();
    end
    req_valid_i = '0;
    tick();
    bus_read(16'h0008, 32'h0000_0201, "status_fp");

    // ---- Round-robin skips a masked requester without stalling ----
    bus_write(16'h0004, 32'h0);
    set_req(0, 40, 2);
    set_req(3, 50, 3);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(3, 50, 3));
      @(negedge clk_i);
      check("rr_mask_ready", 32'(req_ready_o), 32'b1000);
      tick();
    end
    req_valid_i = '0;
    tick();

    // ---- Reset while FULL discards the held result ----
    res_ready_i = 1'b0;
    set_req(1, 1, 1);
    sb.push_back(model(1, 1, 1));
    tick();
    req_valid_i = '0;
    @(negedge clk_i);
    check("pre_rst_valid", 32'(res_valid_o), 32'd1);
    tick();
    rst_i = 1'b1;
    void'(sb.pop_front());
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_valid", 32'(res_valid_o), 32'd0);
    check("post_rst_data",  32'(res_data_o),  32'd0);
    tick();
    bus_read(16'h0008, 32'h0, "status_post_rst");
    res_ready_i = 1'b1;
    set_req(2, 3, 4);
    sb.push_back(model(2, 3, 4));
    @(negedge clk_i);
    check("post_rst_ready", 32'(req_ready_o), 32'b0100);
    tick();
    req_valid_i = '0;
    tick();

    // ---- Combined write+read returns the pre-write value ----
    addr  = 16'h0000;
    wdata = 32'h3;
    wen   = 1'b1;
    ren   = 1'b1;
    tick();
    wen   = 1'b0;
    ren   = 1'b0;
    check("rw_ack",   32'(ack), 32'd1);
    check("rw_rdata", rdata,    32'hF);
    bus_read(16'h0000, 32'h3, "mask_after_rw");

    // ---- Read-only and unmapped addresses ----
    bus_write(16'h000C, 32'h55);
    bus_read(16'h000C, 32'h0, "satcnt_ro");
    bus_write(16'h0014, 32'hFF);
    bus_read(16'h0000, 32'h3, "mask_unmapped_wr");
    bus_read(16'h0020, 32'h0, "unmapped_rd");
`ifndef ADDER_ARBITER_GRANT_STATS_EN
    bus_read(16'h0010, 32'h0, "stats_absent");
`endif

    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
